cr_cdc_toggle_tx: RTL

CR_CDC_TOGGLE_TX -- requirements
Module: cr_cdc_toggle_tx

---
 rtl/cr_cdc_pkg.sv | 14 +
 rtl/cr_dual_rank_synchronizer.sv | 26 ++
 rtl/cr_cdc_toggle_tx.sv | 103 ++++++++++
 3 files changed

// File: rtl/cr_cdc_pkg.sv
// Shared types and defaults for the toggle-handshake CDC sender.
// State encoding plus default payload, timeout and counter sizes.
package cr_cdc_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 1023;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

endpackage

// File: rtl/cr_dual_rank_synchronizer.sv
// Two-flop synchronizer for signals crossing into the clk domain.
// Both ranks reset to RESET_VAL so the output is defined after reset.
module cr_dual_rank_synchronizer #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First rank may go metastable; second rank gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cr_cdc_toggle_tx.sv
// Toggle-handshake sender: holds one payload per request toggle
// until the synchronized ack toggle matches, with error tracking.
module cr_cdc_toggle_tx
  import cr_cdc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             req_tgl,
  output logic [WIDTH-1:0] req_data,
  input  logic             ack_tgl,
  output logic             busy,
  output logic             timeout_err,
  output logic             proto_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int WC_W =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX =
    WC_W'(TIMEOUT);

  state_t          state;
  logic            ack_sync;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] wait_nxt;
  logic            accept;
  logic            done;
  logic            to_set;
  logic            pe_set;

  cr_dual_rank_synchronizer #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_tgl),
    .q     (ack_sync)
  );

  assign in_rdy = (state == IDLE);
  assign busy   = (state == WAIT_ACK);
  assign accept = in_vld && in_rdy;
  assign done   = busy && (ack_sync == req_tgl);

  assign wait_nxt = (wait_cnt == WC_MAX)
                  ? wait_cnt
                  : wait_cnt + 1'b1;

  // Timeout fires on the edge where the wait count lands on TIMEOUT.
  assign to_set = busy && (wait_nxt == WC_MAX);
  // An ack edge with nothing outstanding is a protocol violation.
  assign pe_set = in_rdy && (ack_sync != req_tgl);

  // Handshake FSM: launch on accept, retire when ack matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_tgl  <= 1'b0;
      req_data <= '0;
      wait_cnt <= '0;
      xfer_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_data <= in_data;
            req_tgl  <= ~req_tgl;
            wait_cnt <= '0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          wait_cnt <= wait_nxt;
          if (done) begin
            state    <= IDLE;
            xfer_cnt <= xfer_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky errors; a new set condition beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      timeout_err <= to_set | (timeout_err & ~clr_err);
      proto_err   <= pe_set | (proto_err & ~clr_err);
    end
  end

endmodule
